// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NREQ byte sources share one UART transmitter.
// Multi-byte packets (req_last low) keep the grant until their last byte completes.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [DW-1:0]           tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    arb_busy,
    output logic                    timeout_err
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, HOLD} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [DW-1:0]   txd_q, txd_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel, tsel;
    logic            found, take;

    // Round-robin search: the requester after the last served one has top priority.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                found = 1'b1;
                sel   = IW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gid_d       = gid_q;
        txd_d       = txd_q;
        lock_d      = lock_q;
        cnt_d       = cnt_q;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        take        = 1'b0;
        tsel        = sel;
        case (state_q)
            IDLE: begin
                if (!tx_busy && found) begin
                    req_ready[sel] = 1'b1;
                    take           = 1'b1;
                end
            end
            HOLD: begin
                tsel = gid_q;
                if (!tx_busy && req_valid[gid_q]) begin
                    req_ready[gid_q] = 1'b1;
                    take             = 1'b1;
                end
            end
            START: begin
                tx_start = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT)) begin
                    // Transmitter never acknowledged: drop the byte and any packet lock.
                    timeout_err = 1'b1;
                    lock_d      = 1'b0;
                    rr_ptr_d    = gid_q;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (lock_q) begin
                        state_d = HOLD;
                    end else begin
                        rr_ptr_d = gid_q;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            txd_d   = req_data[int'(tsel)*DW +: DW];
            gid_d   = tsel;
            lock_d  = ~req_last[tsel];
            cnt_d   = '0;
            state_d = START;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= IW'(NREQ - 1);
            gid_q    <= '0;
            txd_q    <= '0;
            lock_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            txd_q    <= txd_d;
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tx_data  = txd_q;
    assign grant_id = gid_q;
    assign arb_busy = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus packet,
// round-robin, timeout and mid-frame reset sequences against a simple UART model.
module tb_uart_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int TO    = 16;
    localparam int FRAME = 6;
    localparam logic [31:0] DATA0 = {8'hC3, 8'hB2, 8'hA1, 8'h55};

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = 4'hF;
    logic [31:0] req_data = DATA0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy, arb_busy, timeout_err;
    logic [1:0]  grant_id;
    logic        auto_tx = 1'b0;
    logic        tb_busy = 1'b0;
    logic        model_busy;
    int          mcnt;
    int          n_vec = 0;
    int          n_miss = 0;
    logic [1:0]  log_gid[$];
    logic [7:0]  log_dat[$];

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic       b;
        logic [3:0] e_rdy;
        logic       e_st;
        logic       e_ab;
        logic [1:0] e_gid;
        logic [7:0] e_txd;
        logic       e_to;
    } vec_t;
    localparam int NV = 24;
    vec_t tbl [NV];

    always #5 sys_clk = ~sys_clk;

    uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .ACK_TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    // UART model: busy rises 2 cycles after the start pulse and lasts FRAME cycles.
    assign model_busy = (mcnt >= 2) && (mcnt < 2 + FRAME);
    assign tx_busy    = auto_tx ? model_busy : tb_busy;

    always @(posedge sys_clk or posedge rst) begin
        if (rst)                               mcnt <= 0;
        else if (tx_start)                     mcnt <= 1;
        else if (mcnt != 0 && mcnt < 2 + FRAME) mcnt <= mcnt + 1;
        else                                   mcnt <= 0;
    end

    always @(posedge sys_clk) begin
        if (!rst && tx_start) begin
            log_gid.push_back(grant_id);
            log_dat.push_back(tx_data);
        end
    end

    function automatic logic [7:0] byte_of(input int g);
        return DATA0[g*8 +: 8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst = 1'b1;
        req_valid = '0;
        req_last = 4'hF;
        req_data = DATA0;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        int k = 0;
        while (log_gid.size() < n && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        if (log_gid.size() < n) chk(nm, 32'(log_gid.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        #1;
        while (arb_busy && k < budget) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        chk(nm, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        logic [1:0] exp_g [5];
        logic [7:0] exp_d [5];

        //            rst   valid  busy  ready  start ab    gid    txd    to
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[6]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};
        tbl[8]  = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};
        tbl[9]  = '{1'b0, 4'h2, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};
        tbl[10] = '{1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd1, 8'hA1, 1'b0};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd1, 8'hA1, 1'b0};
        tbl[13] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd1, 8'hA1, 1'b0};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd1, 8'hA1, 1'b0};
        tbl[15] = '{1'b0, 4'h9, 1'b0, 4'h8, 1'b0, 1'b0, 2'd1, 8'hA1, 1'b0};
        tbl[16] = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 8'hC3, 1'b0};
        tbl[17] = '{1'b0, 4'h1, 1'b1, 4'h0, 1'b0, 1'b1, 2'd3, 8'hC3, 1'b0};
        tbl[18] = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 1'b1, 2'd3, 8'hC3, 1'b0};
        tbl[19] = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0, 2'd3, 8'hC3, 1'b0};
        tbl[20] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[21] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[22] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 2'd0, 8'h55, 1'b0};
        tbl[23] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 8'h55, 1'b0};

        for (int i = 0; i < NV; i++) begin
            @(negedge sys_clk);
            rst       = tbl[i].rst;
            req_valid = tbl[i].v;
            tb_busy   = tbl[i].b;
            #1;
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d tx_start", i), 32'(tx_start), 32'(tbl[i].e_st));
            chk($sformatf("row%0d arb_busy", i), 32'(arb_busy), 32'(tbl[i].e_ab));
            chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].e_gid));
            chk($sformatf("row%0d tx_data", i), 32'(tx_data), 32'(tbl[i].e_txd));
            chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'(tbl[i].e_to));
        end

        // All four requesters always valid: strict rotation 0,1,2,3,0.
        do_reset();
        auto_tx = 1'b1;
        base = log_gid.size();
        req_valid = 4'hF;
        wait_starts(base + 5, 300, "rr frame count");
        req_valid = 4'h0;
        wait_idle(100, "rr idle");
        chk("rr total starts", 32'(log_gid.size()), 32'(base + 5));
        for (int i = 0; i < 5; i++) begin
            exp_g[i] = 2'(i % 4);
            exp_d[i] = byte_of(i % 4);
            if (log_gid.size() > base + i) begin
                chk($sformatf("rr gid%0d", i), 32'(log_gid[base+i]), 32'(exp_g[i]));
                chk($sformatf("rr data%0d", i), 32'(log_dat[base+i]), 32'(exp_d[i]));
            end
        end

        // Requester 1 sends a 3-byte packet while requester 2 waits.
        do_reset();
        base = log_gid.size();
        req_valid = 4'b0110;
        req_last  = 4'b1100;
        for (int b = 0; b < 3; b++) begin
            req_data[15:8] = 8'(8'h11 + b);
            req_last[1]    = (b == 2);
            k = 0;
            #1;
            while (!req_ready[1] && k < 100) begin
                @(negedge sys_clk);
                #1;
                k++;
            end
            chk($sformatf("pkt byte%0d ready", b), 32'(req_ready[1]), 32'd1);
            @(posedge sys_clk);
            #1;
        end
        req_valid[1] = 1'b0;
        wait_starts(base + 4, 200, "pkt start count");
        req_valid[2] = 1'b0;
        wait_idle(100, "pkt idle");
        exp_g[0] = 2'd1; exp_g[1] = 2'd1; exp_g[2] = 2'd1; exp_g[3] = 2'd2;
        exp_d[0] = 8'h11; exp_d[1] = 8'h12; exp_d[2] = 8'h13; exp_d[3] = 8'hB2;
        for (int i = 0; i < 4; i++) begin
            if (log_gid.size() > base + i) begin
                chk($sformatf("pkt gid%0d", i), 32'(log_gid[base+i]), 32'(exp_g[i]));
                chk($sformatf("pkt data%0d", i), 32'(log_dat[base+i]), 32'(exp_d[i]));
            end
        end

        // tx_busy stuck low: timeout 16 cycles after START, then next requester.
        do_reset();
        auto_tx = 1'b0;
        tb_busy = 1'b0;
        req_valid = 4'b0011;
        k = 0;
        #1;
        while (!tx_start && k < 50) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        chk("to start seen", 32'(tx_start), 32'd1);
        chk("to err in start", 32'(timeout_err), 32'd0);
        for (int c = 1; c <= TO + 1; c++) begin
            @(negedge sys_clk);
            #1;
            if (c <= TO) begin
                chk($sformatf("to err c%0d", c), 32'(timeout_err), 32'(c == TO));
                chk($sformatf("to busy c%0d", c), 32'(arb_busy), 32'd1);
            end else begin
                chk("to back idle", 32'(arb_busy), 32'd0);
                chk("to next grant", 32'(req_ready), 32'b0010);
            end
        end
        req_valid = 4'h0;

        // Reset during WAIT_DONE abandons the frame.
        do_reset();
        auto_tx = 1'b1;
        req_valid = 4'b0100;
        k = 0;
        while (!model_busy && k < 50) begin
            @(negedge sys_clk);
            k++;
        end
        @(negedge sys_clk);
        rst = 1'b1;
        req_valid = 4'h0;
        #1;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst start", 32'(tx_start), 32'd0);
        chk("rst arb_busy", 32'(arb_busy), 32'd0);
        chk("rst grant_id", 32'(grant_id), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst timeout", 32'(timeout_err), 32'd0);
        base = log_gid.size();
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("rst no start", 32'(log_gid.size()), 32'(base));
        req_valid = 4'b1010;
        #1;
        chk("rst lowest grant", 32'(req_ready), 32'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, limit 100000 expected earlier");
        $fatal(1);
    end
endmodule
